// File: rtl/ahb_lite_master_if.sv
// AHB-Lite master bundle: command port, write/read beat streams,
// completion status and the AHB-Lite bus itself.
interface ahb_lite_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        wdata_valid;
  logic [31:0] wdata;
  logic        wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        done;
  logic        done_err;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic        HMASTERLOCK;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst,
    input  wdata_valid, wdata,
    input  HRDATA, HREADY, HRESP,
    output cmd_ready, wdata_ready, rdata, rdata_valid, done, done_err,
    output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTERLOCK,
    output HWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_burst,
    output wdata_valid, wdata,
    output HRDATA, HREADY, HRESP,
    input  cmd_ready, wdata_ready, rdata, rdata_valid, done, done_err,
    input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTERLOCK,
    input  HWDATA
  );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite burst master: turns one command into SINGLE/INCRn beats,
// with write back-pressure via BUSY and two-cycle ERROR handling.
module ahb_lite_master (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_lite_master_if.master bus
);
  typedef enum logic [1:0] {
    S_IDLE, S_ADDR, S_DATA, S_ERR
  } state_e;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  state_e      state_q, state_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        hwrite_q, hwrite_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [2:0]  hburst_q, hburst_d;
  logic [4:0]  rem_q, rem_d;
  logic        dp_q, dp_d;
  logic        rv_q, rv_d;
  logic        done_q, done_d;
  logic        derr_q, derr_d;
  logic        live_q, live_d;

  logic [4:0]  nbeats;
  logic [2:0]  burst_enc;
  logic [31:0] last_addr;
  logic        misalign;
  logic        bad;
  logic        accept;
  logic        err_hit;
  logic        wready;
  logic [31:0] step;

  always_comb begin
    nbeats    = 5'd1;
    burst_enc = 3'b000;
    unique case (bus.cmd_burst)
      2'd0: begin nbeats = 5'd1;  burst_enc = 3'b000; end
      2'd1: begin nbeats = 5'd4;  burst_enc = 3'b011; end
      2'd2: begin nbeats = 5'd8;  burst_enc = 3'b101; end
      2'd3: begin nbeats = 5'd16; burst_enc = 3'b111; end
    endcase
  end

  assign last_addr = bus.cmd_addr
                   + (32'(nbeats - 5'd1) << bus.cmd_size);
  assign misalign  = (bus.cmd_size == 3'd1 && bus.cmd_addr[0])
                   || (bus.cmd_size == 3'd2
                       && bus.cmd_addr[1:0] != 2'b00);
  assign bad       = (bus.cmd_size > 3'd2) || misalign
                   || (last_addr[31:10] != bus.cmd_addr[31:10]);

  assign bus.cmd_ready = live_q && state_q == S_IDLE && !done_q;
  assign accept  = bus.cmd_valid && bus.cmd_ready;
  assign err_hit = dp_q && bus.HRESP;
  assign step    = 32'd1 << hsize_q;

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    htrans_d = htrans_q;
    hwrite_d = hwrite_q;
    hsize_d  = hsize_q;
    hburst_d = hburst_q;
    rem_d    = rem_q;
    dp_d     = dp_q;
    rv_d     = 1'b0;
    done_d   = 1'b0;
    derr_d   = 1'b0;
    live_d   = 1'b1;
    wready   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept && bad) begin
          done_d = 1'b1;
          derr_d = 1'b1;
        end else if (accept) begin
          state_d  = S_ADDR;
          haddr_d  = bus.cmd_addr;
          hwrite_d = bus.cmd_write;
          hsize_d  = bus.cmd_size;
          hburst_d = burst_enc;
          rem_d    = nbeats;
          dp_d     = 1'b0;
          htrans_d = (!bus.cmd_write || bus.wdata_valid)
                   ? T_NSEQ : T_IDLE;
        end
      end
      S_ADDR, S_DATA: begin
        if (err_hit) begin
          // cancel whatever address phase is on the bus
          htrans_d = T_IDLE;
          if (bus.HREADY) begin
            state_d = S_IDLE;
            dp_d    = 1'b0;
            done_d  = 1'b1;
            derr_d  = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end else if (bus.HREADY) begin
          if (dp_q && !hwrite_q) begin
            rdata_d = bus.HRDATA;
            rv_d    = 1'b1;
          end
          dp_d = 1'b0;
          if (state_q == S_DATA) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else if (htrans_q[1]) begin
            wready  = hwrite_q;
            if (hwrite_q) hwdata_d = bus.wdata;
            dp_d    = 1'b1;
            haddr_d = haddr_q + step;
            rem_d   = rem_q - 5'd1;
            if (rem_q == 5'd1) begin
              htrans_d = T_IDLE;
              state_d  = S_DATA;
            end else begin
              htrans_d = (!hwrite_q || bus.wdata_valid)
                       ? T_SEQ : T_BUSY;
            end
          end else if (bus.wdata_valid) begin
            htrans_d = (htrans_q == T_IDLE) ? T_NSEQ : T_SEQ;
          end
        end
      end
      S_ERR: begin
        htrans_d = T_IDLE;
        if (bus.HREADY) begin
          state_d = S_IDLE;
          dp_d    = 1'b0;
          done_d  = 1'b1;
          derr_d  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      haddr_q  <= '0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      htrans_q <= T_IDLE;
      hwrite_q <= 1'b0;
      hsize_q  <= '0;
      hburst_q <= '0;
      rem_q    <= '0;
      dp_q     <= 1'b0;
      rv_q     <= 1'b0;
      done_q   <= 1'b0;
      derr_q   <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      htrans_q <= htrans_d;
      hwrite_q <= hwrite_d;
      hsize_q  <= hsize_d;
      hburst_q <= hburst_d;
      rem_q    <= rem_d;
      dp_q     <= dp_d;
      rv_q     <= rv_d;
      done_q   <= done_d;
      derr_q   <= derr_d;
      live_q   <= live_d;
    end
  end

  assign bus.wdata_ready = wready;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rv_q;
  assign bus.done        = done_q;
  assign bus.done_err    = derr_q;
  assign bus.HADDR       = haddr_q;
  assign bus.HWRITE      = hwrite_q;
  assign bus.HSIZE       = hsize_q;
  assign bus.HBURST      = hburst_q;
  assign bus.HPROT       = 4'b0011;
  assign bus.HTRANS      = htrans_q;
  assign bus.HMASTERLOCK = 1'b0;
  assign bus.HWDATA      = hwdata_q;
endmodule

// File: tb/tb_ahb_lite_master.sv
// Randomized bench for ahb_lite_master: beat-level reference model
// plus directed bursts, wait states, BUSY gaps, errors and resets.
module tb_ahb_lite_master;
  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  always #5 HCLK = ~HCLK;

  ahb_lite_master_if bus();
  ahb_lite_master dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  // command stimulus
  bit          c_valid, c_write;
  logic [31:0] c_addr;
  logic [2:0]  c_size;
  logic [1:0]  c_burst;

  // reference model: command progress counted in beats
  bit          m_live, m_act, m_show, m_dp, m_err1, m_write, m_acc;
  int          m_iss, m_nb, m_dpi;
  logic [31:0] m_addr;
  logic [2:0]  m_size;
  bit          e_done, e_derr, e_rv;
  logic [31:0] e_rdata;
  logic [31:0] wbeat [16];

  // slave / source knobs
  int p_wait, p_wv, err_beat, wait_beat, wait_n, gap_after, gap_len;
  int wcnt, gcnt;

  // observation log
  logic [1:0]  lg_t [$];
  logic [31:0] lg_a [$];
  int          n_busy, n_stall, n_rv, wr_run, wr_max, cyc, acc_cyc;
  int          done_cyc;
  logic [31:0] busy_addr, stall_addr;
  bit          seen_done, seen_derr;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int beats_of(logic [1:0] b);
    return (b == 0) ? 1 : (b == 1) ? 4 : (b == 2) ? 8 : 16;
  endfunction

  function automatic logic [2:0] hburst_of(int nb);
    return (nb == 1) ? 3'b000 : (nb == 4) ? 3'b011
         : (nb == 8) ? 3'b101 : 3'b111;
  endfunction

  function automatic logic [1:0] exp_htrans();
    if (!m_act || m_err1 || m_iss >= m_nb) return 2'b00;
    if (m_show) return (m_iss == 0) ? 2'b10 : 2'b11;
    return (m_iss == 0) ? 2'b00 : 2'b01;
  endfunction

  function automatic bit illegal(logic [31:0] a, logic [2:0] s,
                                 int nb);
    longint first, last;
    if (s > 2) return 1;
    if ((a % (32'd1 << s)) != 0) return 1;
    first = longint'(a);
    last  = first + longint'((nb - 1) * (1 << s));
    return (first / 1024) != (last / 1024);
  endfunction

  task automatic model_reset();
    m_live = 0; m_act = 0; m_show = 0; m_dp = 0; m_err1 = 0;
    m_iss = 0; m_nb = 1;
    e_done = 0; e_derr = 0; e_rv = 0;
  endtask

  task automatic step();
    bit rdy, rsp, wv, cd;
    logic [31:0] rd;
    @(negedge HCLK);
    rdy = 1; rsp = 0; wv = 0; rd = $urandom;
    if (HRESETn) begin
      if (m_act && m_err1) rsp = 1;
      else if (m_act && m_dp) begin
        if (m_dpi == err_beat) begin rdy = 0; rsp = 1; end
        else if (m_dpi == wait_beat && wcnt < wait_n) begin
          rdy = 0; wcnt++;
        end else if ($urandom_range(99) < p_wait) rdy = 0;
      end
      if (gcnt > 0 && gcnt < gap_len) gcnt++;
      else begin
        wv = ($urandom_range(99) < p_wv);
        if (gcnt == 0 && m_act && m_write && m_show && rdy && !rsp
            && m_iss == gap_after - 1) begin
          wv = 0; gcnt = 1;
        end
      end
    end
    bus.HREADY      = rdy;
    bus.HRESP       = rsp;
    bus.HRDATA      = rd;
    bus.wdata_valid = wv;
    bus.wdata       = wbeat[m_iss % 16];
    bus.cmd_valid   = c_valid;
    bus.cmd_write   = c_write;
    bus.cmd_addr    = c_addr;
    bus.cmd_size    = c_size;
    bus.cmd_burst   = c_burst;
    #1;
    if (!HRESETn) begin
      chk("rst_htrans", bus.HTRANS, 0);
      chk("rst_haddr", bus.HADDR, 0);
      chk("rst_hwrite", bus.HWRITE, 0);
      chk("rst_hsize", bus.HSIZE, 0);
      chk("rst_hburst", bus.HBURST, 0);
      chk("rst_hwdata", bus.HWDATA, 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_rvalid", bus.rdata_valid, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_done_err", bus.done_err, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      model_reset();
    end else begin
      chk("cmd_ready", bus.cmd_ready, m_live && !m_act && !e_done);
      chk("hprot", bus.HPROT, 4'b0011);
      chk("hmastlock", bus.HMASTERLOCK, 0);
      chk("htrans", bus.HTRANS, exp_htrans());
      if (m_act && !m_err1 && m_iss < m_nb)
        chk("haddr", bus.HADDR, m_addr + (m_iss << m_size));
      if (m_act) begin
        chk("hwrite", bus.HWRITE, m_write);
        chk("hsize", bus.HSIZE, m_size);
        chk("hburst", bus.HBURST, hburst_of(m_nb));
      end
      chk("wdata_ready", bus.wdata_ready,
          m_act && !m_err1 && m_write && m_show && m_iss < m_nb
          && rdy && !(m_dp && rsp));
      if (m_act && m_dp && m_write)
        chk("hwdata", bus.HWDATA, wbeat[m_dpi]);
      chk("rdata_valid", bus.rdata_valid, e_rv);
      if (e_rv) chk("rdata", bus.rdata, e_rdata);
      chk("done", bus.done, e_done);
      chk("done_err", bus.done_err, e_derr);
      // observation log for the directed pins
      if (bus.HTRANS[1] && rdy) begin
        lg_t.push_back(bus.HTRANS);
        lg_a.push_back(bus.HADDR);
      end
      if (bus.HTRANS[1] && !rdy) begin
        n_stall++; stall_addr = bus.HADDR;
      end
      if (bus.HTRANS == 2'b01) begin
        n_busy++; busy_addr = bus.HADDR;
      end
      if (bus.wdata_ready) begin
        wr_run++;
        if (wr_run > wr_max) wr_max = wr_run;
      end else wr_run = 0;
      if (bus.rdata_valid) n_rv++;
      if (bus.done) begin
        seen_done = 1; seen_derr = bus.done_err; done_cyc = cyc;
      end
      // advance the model across the coming rising edge
      cd = e_done;
      e_done = 0; e_derr = 0; e_rv = 0;
      if (!m_act) begin
        if (c_valid && m_live && !cd) begin
          m_acc = 1; acc_cyc = cyc;
          if (illegal(c_addr, c_size, beats_of(c_burst))) begin
            e_done = 1; e_derr = 1;
          end else begin
            m_act = 1; m_iss = 0; m_dp = 0; m_err1 = 0;
            m_nb = beats_of(c_burst); m_addr = c_addr;
            m_size = c_size; m_write = c_write;
            m_show = !c_write || wv;
          end
        end
      end else if (m_err1) begin
        if (rdy) begin e_done = 1; e_derr = 1; m_act = 0; end
      end else if (m_dp && rsp) begin
        if (rdy) begin e_done = 1; e_derr = 1; m_act = 0; end
        else m_err1 = 1;
      end else if (rdy) begin
        if (m_dp) begin
          if (!m_write) begin e_rv = 1; e_rdata = rd; end
          m_dp = 0;
        end
        if (m_iss < m_nb) begin
          if (m_show) begin
            m_dp = 1; m_dpi = m_iss; m_iss++; wcnt = 0;
          end
          m_show = (m_iss < m_nb) && (!m_write || wv);
        end
        if (m_iss == m_nb && !m_dp) begin e_done = 1; m_act = 0; end
      end
    end
    cyc++;
  endtask

  task automatic clear_log();
    lg_t.delete(); lg_a.delete();
    n_busy = 0; n_stall = 0; n_rv = 0; wr_run = 0; wr_max = 0;
    seen_done = 0; seen_derr = 0; gcnt = 0; wcnt = 0;
    done_cyc = -1; acc_cyc = -1;
  endtask

  task automatic issue(bit w, logic [31:0] a, logic [2:0] s,
                       logic [1:0] b);
    for (int i = 0; i < 16; i++) wbeat[i] = $urandom;
    clear_log();
    c_valid = 1; c_write = w; c_addr = a; c_size = s; c_burst = b;
    m_acc = 0;
    for (int i = 0; i < 10 && !m_acc; i++) step();
    c_valid = 0;
    chk("accepted", m_acc, 1);
  endtask

  task automatic run_cmd(bit w, logic [31:0] a, logic [2:0] s,
                         logic [1:0] b);
    issue(w, a, s, b);
    for (int i = 0; i < 3000 && !seen_done; i++) step();
    chk("done_seen", seen_done, 1);
  endtask

  task automatic knobs(int pw, int pv);
    p_wait = pw; p_wv = pv; err_beat = -1;
    wait_beat = -1; wait_n = 0; gap_after = -100; gap_len = 0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    c_valid = 0; c_write = 0; c_addr = 0; c_size = 0; c_burst = 0;
    cyc = 0;
    bus.HREADY = 1; bus.HRESP = 0; bus.HRDATA = 0;
    bus.wdata_valid = 0; bus.wdata = 0;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0;
    bus.cmd_size = 0; bus.cmd_burst = 0;
    for (int i = 0; i < 16; i++) wbeat[i] = 0;
    model_reset();
    knobs(0, 100);
    clear_log();
    repeat (3) step();
    HRESETn = 1; m_live = 1;
    step();
    chk("ready_after_rst", bus.cmd_ready, 1);

    // zero-wait INCR4 write
    knobs(0, 100);
    run_cmd(1, 32'h100, 2, 1);
    chk("w4_beats", lg_t.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("w4_htrans%0d", i), lg_t[i], (i == 0) ? 2 : 3);
      chk($sformatf("w4_haddr%0d", i), lg_a[i], 32'h100 + 4 * i);
    end
    chk("w4_wready_run", wr_max, 4);
    chk("w4_busy", n_busy, 0);
    chk("w4_derr", seen_derr, 0);

    // INCR4 read, two wait states on beat 2
    knobs(0, 100);
    wait_beat = 1; wait_n = 2;
    run_cmd(0, 32'h200, 2, 1);
    chk("r4_rvalid", n_rv, 4);
    chk("r4_stall", n_stall, 2);
    chk("r4_stall_addr", stall_addr, 32'h208);
    chk("r4_derr", seen_derr, 0);

    // INCR8 write with a 3-cycle source gap after beat 3
    knobs(0, 100);
    gap_after = 3; gap_len = 3;
    run_cmd(1, 32'h40, 2, 2);
    chk("w8_beats", lg_t.size(), 8);
    chk("w8_busy", n_busy, 3);
    chk("w8_busy_addr", busy_addr, 32'h4C);
    chk("w8_derr", seen_derr, 0);

    // SINGLE read answered with ERROR
    knobs(0, 100);
    err_beat = 0;
    run_cmd(0, 32'h0, 2, 0);
    chk("err_beats", lg_t.size(), 1);
    chk("err_rvalid", n_rv, 0);
    chk("err_derr", seen_derr, 1);

    // rejections: 1KB crossing, misaligned, oversize
    knobs(0, 100);
    run_cmd(1, 32'h3F8, 2, 3);
    chk("rej_beats", lg_t.size(), 0);
    chk("rej_derr", seen_derr, 1);
    chk("rej_latency", done_cyc - acc_cyc, 1);
    run_cmd(0, 32'h102, 2, 0);
    chk("mis_derr", seen_derr, 1);
    run_cmd(0, 32'h100, 3, 0);
    chk("size_derr", seen_derr, 1);

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      bit w;
      logic [2:0] s;
      logic [1:0] b;
      logic [31:0] a;
      w = 1'($urandom_range(1));
      b = 2'($urandom_range(3));
      s = ($urandom_range(9) == 0) ? 3'd3 : 3'($urandom_range(2));
      a = ($urandom & 32'h000F_FFFF) & ~((32'd1 << s) - 1);
      if ($urandom_range(7) == 0) a = a | 32'd1;
      knobs($urandom_range(50), $urandom_range(40, 100));
      if ($urandom_range(5) == 0)
        err_beat = $urandom_range(beats_of(b) - 1);
      run_cmd(w, a, s, b);
    end

    // reset in the middle of an INCR8 read
    knobs(20, 100);
    issue(0, 32'h400, 2, 2);
    repeat (4) step();
    HRESETn = 0;
    #1;
    chk("mid_rst_htrans", bus.HTRANS, 0);
    chk("mid_rst_done", bus.done, 0);
    model_reset();
    repeat (2) step();
    HRESETn = 1; m_live = 1;
    seen_done = 0;
    repeat (3) step();
    chk("mid_rst_no_done", seen_done, 0);

    // recovery after reset
    knobs(10, 90);
    run_cmd(1, 32'h800, 1, 1);
    chk("post_rst_derr", seen_derr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 HCLK  in  1  bus clock; all state advances on rising edge.
REQ-002 HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-003 cmd_valid  in  1  command request.
REQ-004 cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-005 cmd_write  in  1  1=write, 0=read.
REQ-006 cmd_addr  in  32  start address.
REQ-007 cmd_size  in  3  HSIZE encoding.
REQ-008 cmd_burst  in  2  0=SINGLE, 1=INCR4, 2=INCR8, 3=INCR16.
REQ-009 wdata_valid  in  1  next write beat available.
REQ-010 wdata  in  32  write beat data.
REQ-011 wdata_ready  out  1  write beat consumed when wdata_valid && wdata_ready.
REQ-012 rdata  out  32  read beat data.
REQ-013 rdata_valid  out  1  one-cycle pulse per completed OKAY read beat.
REQ-014 done  out  1  one-cycle pulse, command finished.
REQ-015 done_err  out  1  qualifies done; 1 = rejected or ERROR response.
REQ-016 HADDR  out  32; HWRITE out 1; HSIZE out 3; HBURST out 3; HPROT out 4; HTRANS out 2; HMASTERLOCK out 1; HWDATA out 32  AHB-Lite master outputs.
REQ-017 HRDATA  in  32; HREADY  in  1; HRESP  in  1  AHB-Lite responses (HRESP 0=OKAY, 1=ERROR).

Function
REQ-018 All AHB outputs, rdata, rdata_valid, done, done_err SHALL be registered.
REQ-019 HPROT SHALL be constant 4'b0011; HMASTERLOCK SHALL be constant 0.
REQ-020 cmd_ready SHALL be 1 only in state IDLE.
REQ-021 States: IDLE, ADDR (address phase of a beat pending/issuing), DATA (last data phase only), ERR (second ERROR cycle).
REQ-022 On accept, cmd with cmd_size>2 or with last beat address crossing a 1KB boundary SHALL be rejected: no bus activity, done=done_err=1 next cycle, remain IDLE.
REQ-023 Misaligned cmd_addr for cmd_size SHALL be rejected identically.
REQ-024 Beat count: 1/4/8/16 for cmd_burst 0/1/2/3; HBURST SHALL be 000/011/101/111 respectively.
REQ-025 First beat HTRANS=NONSEQ, later beats SEQ; HADDR increments by 1<<cmd_size per accepted beat.
REQ-026 Write beats: a beat's address phase SHALL be issued only when wdata_valid=1; otherwise HTRANS=BUSY (mid-burst) or IDLE (first beat), HADDR held at the pending beat address.
REQ-027 wdata_ready SHALL be 1 exactly in cycles where a write address phase is driven and HREADY=1; consumed wdata SHALL appear on HWDATA next cycle and hold until its data phase completes.
REQ-028 Address/control SHALL hold stable while HREADY=0.
REQ-029 A data phase completes on HREADY=1; read completion with HRESP=0 SHALL register HRDATA to rdata and pulse rdata_valid next cycle.
REQ-030 After last address phase accepted, HTRANS=IDLE (state DATA); done pulses (done_err=0) the cycle after the last data phase completes OKAY; return IDLE.
REQ-031 On HRESP=1 && HREADY=0, next cycle HTRANS SHALL be IDLE (cancel remaining beats), state ERR; no rdata_valid for the errored beat.
REQ-032 In ERR, on HREADY=1, done=done_err=1 next cycle, return IDLE; no further beats of that command issued.
REQ-033 HRESP=1 with HREADY=1 in a first cycle SHALL be treated as OKAY-less error, same as REQ-031/032.
REQ-034 Next command MAY be accepted the cycle after done.

Reset
REQ-035 On HRESETn=0: state IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HBURST=0, HWDATA=0, rdata=0, rdata_valid=0, done=0, done_err=0, cmd_ready=0 during reset, 1 after release.
REQ-036 Reset mid-burst SHALL abandon the command with no done pulse.

Verification
REQ-037 Zero-wait memory, INCR4 write at 0x100, size 2, wdata always valid -> HTRANS NONSEQ,SEQ,SEQ,SEQ at 0x100..0x10C, 4 consecutive wdata_ready, done=1 done_err=0.
REQ-038 INCR4 read, slave inserts 2 wait states on beat 2 -> HADDR held, 4 rdata_valid pulses with matching HRDATA, done_err=0.
REQ-039 INCR8 write, wdata_valid low 3 cycles after beat 3 -> 3 BUSY cycles at beat-4 address, then SEQ resumes, 8 beats total.
REQ-040 SINGLE read to default slave (ERROR response) -> HTRANS IDLE in 2nd ERROR cycle, no rdata_valid, done=1 done_err=1.
REQ-041 INCR16 size 2 at 0x3F8 -> rejected, no HTRANS activity, done=done_err=1 next cycle; HRESETn low mid-INCR8 -> HTRANS=IDLE immediately, no done.
